// File: rtl/genesis_pad_pkg.sv
// Shared constants and types for the Genesis pad scanner.
// Button bit map, raw pin indices and the scan state enum.
package genesis_pad_pkg;

    localparam int NUM_BUTTONS = 11;
    localparam int NUM_PINS    = 6;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_START = 5;
    localparam int BTN_Z     = 6;
    localparam int BTN_Y     = 7;
    localparam int BTN_X     = 8;
    localparam int BTN_B     = 9;
    localparam int BTN_C     = 10;

    // Raw pin vector order inside the scanner
    localparam int PIN_UP_Z    = 0;
    localparam int PIN_DOWN_Y  = 1;
    localparam int PIN_LEFT_X  = 2;
    localparam int PIN_RIGHT   = 3;
    localparam int PIN_A_B     = 4;
    localparam int PIN_START_C = 5;

    typedef enum logic [1:0] {
        LO_WAIT,
        HI_WAIT,
        PUBLISH,
        GAP
    } scan_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/genesis_pad_scanner_if.sv
// Pad pins, select drive and the published button word.
// master: scanner side; slave: pad/consumer side.
interface genesis_pad_scanner_if;
    import genesis_pad_pkg::*;

    logic                   up_z;
    logic                   down_y;
    logic                   left_x;
    logic                   right;
    logic                   a_b;
    logic                   start_c;
    logic                   select_signal;
    logic [NUM_BUTTONS-1:0] buttons_out;
    logic                   scan_valid;
    logic [NUM_BUTTONS-1:0] press_edge;

    modport master (
        input  up_z, down_y, left_x, right, a_b, start_c,
        output select_signal, buttons_out, scan_valid, press_edge
    );

    modport slave (
        output up_z, down_y, left_x, right, a_b, start_c,
        input  select_signal, buttons_out, scan_valid, press_edge
    );

endinterface

// File: rtl/genesis_pad_scanner_pad_sync.sv
// Two-flop synchronizer for the six raw pad pins.
// Ports: clk, reset, pins_in (async), pins_out (synced); resets to released.
module pad_sync
    import genesis_pad_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_PINS-1:0] pins_in,
    output logic [NUM_PINS-1:0] pins_out
);

    logic [NUM_PINS-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta     <= '1;
            pins_out <= '1;
        end else begin
            meta     <= pins_in;
            pins_out <= meta;
        end
    end

endmodule

// File: rtl/genesis_pad_scanner.sv
// Genesis 3/6-button pad scanner: drives select, samples both halves,
// publishes an 11-bit active-high word with scan_valid and press_edge.
// Ports: clk, reset (sync, active-high), pad (genesis_pad_scanner_if.master).
// Option: GENESIS_PAD_FILTER_EN publishes only when two scans agree.
module genesis_pad_scanner
    import genesis_pad_pkg::*;
#(
    parameter int SETTLE_CYCLES = 50,
    parameter int GAP_CYCLES    = 1000
) (
    input logic                   clk,
    input logic                   reset,
    genesis_pad_scanner_if.master pad
);

    localparam int CNT_W = $clog2(max2(SETTLE_CYCLES, GAP_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

    scan_state_e            state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [NUM_BUTTONS-1:0] cand, cand_nxt;
    logic [NUM_BUTTONS-1:0] btn_q;
    logic [NUM_BUTTONS-1:0] edge_q;
    logic                   valid_q;
    logic                   sel_q, sel_nxt;
    logic                   publish;
    logic                   accept;

    logic [NUM_PINS-1:0] pins_raw;
    logic [NUM_PINS-1:0] pins_sync;
    logic [NUM_PINS-1:0] pressed;

    assign pins_raw = {pad.start_c, pad.a_b, pad.right,
                       pad.left_x, pad.down_y, pad.up_z};

    pad_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .pins_in  (pins_raw),
        .pins_out (pins_sync)
    );

    assign pressed = ~pins_sync;

`ifdef GENESIS_PAD_FILTER_EN
    logic [NUM_BUTTONS-1:0] hist;
    assign accept = (cand == hist);
`else
    assign accept = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        cand_nxt  = cand;
        sel_nxt   = 1'b1;
        publish   = 1'b0;
        unique case (state)
            LO_WAIT: begin
                sel_nxt = 1'b0;
                // select still high: first cycle after reset, start T0 here
                if (sel_q) begin
                    cnt_nxt = '0;
                end else if (cnt == SETTLE_LAST) begin
                    state_nxt = HI_WAIT;
                    cnt_nxt   = '0;
                    sel_nxt   = 1'b1;
                    cand_nxt[BTN_UP]    = pressed[PIN_UP_Z];
                    cand_nxt[BTN_DOWN]  = pressed[PIN_DOWN_Y];
                    cand_nxt[BTN_LEFT]  = pressed[PIN_LEFT_X];
                    cand_nxt[BTN_RIGHT] = pressed[PIN_RIGHT];
                    cand_nxt[BTN_A]     = pressed[PIN_A_B];
                    cand_nxt[BTN_START] = pressed[PIN_START_C];
                end
            end
            HI_WAIT: begin
                if (cnt == SETTLE_LAST) begin
                    state_nxt = PUBLISH;
                    cnt_nxt   = '0;
                    cand_nxt[BTN_Z] = pressed[PIN_UP_Z];
                    cand_nxt[BTN_Y] = pressed[PIN_DOWN_Y];
                    cand_nxt[BTN_X] = pressed[PIN_LEFT_X];
                    cand_nxt[BTN_B] = pressed[PIN_A_B];
                    cand_nxt[BTN_C] = pressed[PIN_START_C];
                end
            end
            PUBLISH: begin
                state_nxt = GAP;
                cnt_nxt   = '0;
                publish   = accept;
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = LO_WAIT;
                    cnt_nxt   = '0;
                    sel_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = LO_WAIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LO_WAIT;
            cnt     <= '0;
            cand    <= '0;
            sel_q   <= 1'b1;
            btn_q   <= '0;
            edge_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cand    <= cand_nxt;
            sel_q   <= sel_nxt;
            valid_q <= publish;
            edge_q  <= publish ? (cand & ~btn_q) : '0;
            if (publish)
                btn_q <= cand;
        end
    end

`ifdef GENESIS_PAD_FILTER_EN
    always_ff @(posedge clk) begin
        if (reset)
            hist <= '0;
        else if (state == PUBLISH)
            hist <= cand;
    end
`endif

    assign pad.select_signal = sel_q;
    assign pad.buttons_out   = btn_q;
    assign pad.scan_valid    = valid_q;
    assign pad.press_edge    = edge_q;

endmodule

// File: tb/tb_genesis_pad_scanner.sv
// Scoreboard bench for genesis_pad_scanner.
// Driver pushes expected publishes; a negedge monitor pops and compares.
module tb_genesis_pad_scanner;

    localparam int S   = 4;
    localparam int G   = 3;
    localparam int PER = 2 * S + 1 + G;

    typedef struct {
        logic [10:0] btn;
        logic [10:0] edg;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    bit   started = 1'b0;

    exp_t        q[$];
    logic [10:0] mon_last = '0;
    logic [10:0] m_pub = '0;
    logic [10:0] m_hist = '0;
    int          hi_pin[5] = '{0, 1, 2, 4, 5};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    genesis_pad_scanner_if bus();

    genesis_pad_scanner #(
        .SETTLE_CYCLES (S),
        .GAP_CYCLES    (G)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pad   (bus)
    );

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endfunction

    // Pin vector order: {start_c, a_b, right, left_x, down_y, up_z}
    task automatic set_pins(input logic [5:0] p);
        {bus.start_c, bus.a_b, bus.right,
         bus.left_x, bus.down_y, bus.up_z} = p;
    endtask

    // Buttons 0-5 come from the low phase pins 0-5; 6-10 from the
    // high phase pins up_z, down_y, left_x, a_b, start_c.
    function automatic logic [10:0] word_of(logic [5:0] lo, logic [5:0] hi);
        logic [10:0] w;
        w = '0;
        for (int b = 0; b < 6; b++)
            w[b] = ~lo[b];
        for (int b = 0; b < 5; b++)
            w[6 + b] = ~hi[hi_pin[b]];
        return w;
    endfunction

    task automatic model_scan(input logic [10:0] c, input int t0);
        bit pub;
        exp_t e;
`ifdef GENESIS_PAD_FILTER_EN
        pub = (c == m_hist);
`else
        pub = 1'b1;
`endif
        m_hist = c;
        if (pub) begin
            e.btn = c;
            e.edg = c & ~m_pub;
            e.cyc = t0 + 2 * S + 1;
            q.push_back(e);
            m_pub = c;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_pins(6'h3F);
        @(posedge clk);
        #1;
        chk("rst select", 32'(bus.select_signal), 32'd1);
        chk("rst buttons", 32'(bus.buttons_out), 32'd0);
        chk("rst valid", 32'(bus.scan_valid), 32'd0);
        chk("rst edge", 32'(bus.press_edge), 32'd0);
        m_pub = '0;
        m_hist = '0;
        mon_last = '0;
        q.delete();
        reset = 1'b0;
    endtask

    // Runs one full scan starting at the next edge (T0).
    // abort_at >= 0 pulses reset after that edge instead of finishing.
    task automatic run_scan(input logic [5:0] lo, input logic [5:0] hi,
                            input int abort_at);
        int t0;
        t0 = 0;
        for (int k = 0; k < PER; k++) begin
            @(posedge clk);
            #1;
            if (k == 0)
                t0 = cyc;
            chk("select", 32'(bus.select_signal), (k < S) ? 32'd0 : 32'd1);
            if (k == abort_at) begin
                do_reset();
                return;
            end
            if (k == 1)
                set_pins(lo);
            if (k == S)
                set_pins(hi);
            if (k == 2 * S)
                model_scan(word_of(lo, hi), t0);
        end
    endtask

    always @(negedge clk) begin
        if (started && !reset) begin
            if (bus.scan_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected scan_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("buttons", 32'(bus.buttons_out), 32'(e.btn));
                    chk("press_edge", 32'(bus.press_edge), 32'(e.edg));
                    chk("valid time", 32'(cyc), 32'(e.cyc));
                    mon_last = e.btn;
                end
            end else begin
                chk("idle edge", 32'(bus.press_edge), 32'd0);
                chk("hold", 32'(bus.buttons_out), 32'(mon_last));
            end
        end
    end

    initial begin
        reset = 1'b1;
        set_pins(6'h3F);
        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;
        do_reset();

        run_scan(6'h3F, 6'h3F, -1);
        run_scan(6'h3F, 6'h3F, -1);
        run_scan(6'h3E, 6'h3F, -1);
        run_scan(6'h3E, 6'h3F, -1);
        run_scan(6'h00, 6'h00, -1);
        run_scan(6'h3F, 6'h3F, -1);
        run_scan(6'h3F, 6'h2F, -1);
        run_scan(6'h3F, 6'h1F, -1);
        run_scan(6'h3F, 6'h1F, -1);

        for (int i = 0; i < 20; i++) begin
            logic [5:0] lo, hi;
            lo = 6'($urandom);
            hi = 6'($urandom);
            if (i % 3 == 0) begin
                run_scan(lo, hi, -1);
                run_scan(lo, hi, -1);
            end else begin
                run_scan(lo, hi, -1);
            end
        end

        run_scan(6'h00, 6'h00, S + 2);
        run_scan(6'h3F, 6'h3F, -1);
        run_scan(6'h35, 6'h2A, -1);
        run_scan(6'h35, 6'h2A, -1);

        for (int w = 0; w < 2 * PER && q.size() != 0; w++)
            @(posedge clk);
        #1;
        chk("drain", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
